// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the storage-register arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package ram_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LOCK_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping, as one-hot.
// Latency: combinational.
// Backpressure: none; vld low when no request is set.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            vld
);

    logic [PW-1:0] j;

    always_comb begin
        win = '0;
        vld = 1'b0;
        j   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (!vld && req[j]) begin
                win[j] = 1'b1;
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one falling-edge storage register.
// Latency: grant the cycle after req is seen, one-cycle ack the cycle after that.
// Backpressure: requesters hold req until ack; one access per two cycles.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic                   reg_en,
    output logic [DATA_W-1:0]      reg_din,
    input  logic [DATA_W-1:0]      reg_dout
);

    localparam int PW = $clog2(NREQ);

    state_t                state;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         win_idx;
    logic                  lk_vld;
    logic [PW-1:0]         lk_own;
    logic [LOCK_CNT_W-1:0] lk_cnt;

    logic [PW-1:0]         ptr_nxt;
    logic                  lk_vld_nxt;
    logic [PW-1:0]         lk_own_nxt;
    logic [LOCK_CNT_W-1:0] lk_cnt_nxt;

    logic [NREQ-1:0]       own_mask;
    logic [NREQ-1:0]       lock_win;
    logic [NREQ-1:0]       rr_win;
    logic [NREQ-1:0]       pick;
    logic                  lock_hit;
    logic                  rr_vld;
    logic [PW-1:0]         pick_idx;
    logic [DATA_W-1:0]     pick_wdata;
    logic                  pick_we;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Pointer and lock bookkeeping settle first so an ACK->GRANT pick sees the updated state.
    always_comb begin
        ptr_nxt    = ptr;
        lk_vld_nxt = lk_vld;
        lk_own_nxt = lk_own;
        lk_cnt_nxt = lk_cnt;
        if (state == ACK) begin
            if (((lock & gnt) != '0) && (int'(lk_cnt) + 1 < MAX_LOCK)) begin
                lk_vld_nxt = 1'b1;
                lk_own_nxt = win_idx;
                lk_cnt_nxt = lk_cnt + 1'b1;
            end else begin
                lk_vld_nxt = 1'b0;
                lk_cnt_nxt = '0;
                ptr_nxt    = wrap_inc(win_idx);
            end
        end else if (lk_vld && !req[lk_own]) begin
            lk_vld_nxt = 1'b0;
            lk_cnt_nxt = '0;
        end
    end

    always_comb begin
        own_mask = '0;
        if (lk_vld_nxt) begin
            own_mask[lk_own_nxt] = 1'b1;
        end
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_lock_pick (
        .req (req & own_mask),
        .ptr (lk_own_nxt),
        .win (lock_win),
        .vld (lock_hit)
    );

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .req (req),
        .ptr (ptr_nxt),
        .win (rr_win),
        .vld (rr_vld)
    );

    always_comb begin
        pick       = lock_hit ? lock_win : rr_win;
        pick_idx   = '0;
        pick_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx   = PW'(i);
                pick_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
        pick_we = |(we & pick);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win_idx <= '0;
            lk_vld  <= 1'b0;
            lk_own  <= '0;
            lk_cnt  <= '0;
            gnt     <= '0;
            ack     <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            reg_en  <= 1'b0;
            reg_din <= '0;
        end else begin
            ptr    <= ptr_nxt;
            lk_vld <= lk_vld_nxt;
            lk_own <= lk_own_nxt;
            lk_cnt <= lk_cnt_nxt;
            case (state)
                IDLE, ACK: begin
                    ack <= '0;
                    if (rr_vld) begin
                        state   <= GRANT;
                        gnt     <= pick;
                        win_idx <= pick_idx;
                        busy    <= 1'b1;
                        reg_en  <= pick_we;
                        if (pick_we) begin
                            reg_din <= pick_wdata;
                        end
                    end else begin
                        state  <= IDLE;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        reg_en <= 1'b0;
                    end
                end
                GRANT: begin
                    // Register wrote at the falling edge, so this sample is the write-through value.
                    state  <= ACK;
                    ack    <= gnt;
                    rdata  <= reg_dout;
                    reg_en <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req, we, lock;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt, ack;
    logic [DW-1:0]     rdata, reg_din, reg_dout;
    logic              busy, reg_en;
    logic [DW-1:0]     stor = 32'h0;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   rem[NREQ];
    int   ack_cyc[NREQ];
    int   en_cnt, en_cyc, last_cyc;
    int   n_chk = 0;
    int   n_fail = 0;

    ram_arbiter #(.NREQ(NREQ), .DATA_W(DW), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .reg_en(reg_en),
        .reg_din(reg_din), .reg_dout(reg_dout)
    );

    always #5 clk = ~clk;

    // Storage register model: captures on the falling edge while enabled, never reset.
    always @(negedge clk) if (reg_en) stor <= reg_din;
    assign reg_dout = stor;

    task automatic clear_inputs();
        req = '0; we = '0; lock = '0; wdata = '0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input int i, input logic w, input logic [31:0] d, input int n, input logic l);
        req[i] = 1'b1;
        we[i] = w;
        wdata[i*DW +: DW] = d;
        rem[i] = n;
        lock[i] = l;
    endtask

    task automatic push(input int i, input logic [31:0] d);
        exp_t e;
        e.idx = i;
        e.data = d;
        sb.push_back(e);
    endtask

    // Acts as all requesters: drops req after the requested number of acks and scores each ack.
    task automatic run(input int budget);
        int   cyc;
        int   ai;
        int   left;
        logic prev_en;
        exp_t e;
        cyc = 0; prev_en = 1'b0; en_cnt = 0; en_cyc = -1;
        for (int i = 0; i < NREQ; i++) ack_cyc[i] = -1;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (reg_en) begin
                en_cnt++;
                if (en_cyc < 0) en_cyc = cyc;
                n_chk++;
                if (prev_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reg_en_consecutive cycle=%0d got prev=%b want 0", cyc, prev_en);
                end
            end
            prev_en = reg_en;
            if (ack != '0) begin
                ai = -1;
                for (int i = 0; i < NREQ; i++) if (ack[i]) ai = i;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack cycle=%0d got ack=%b want none", cyc, ack);
                end else begin
                    e = sb.pop_front();
                    if (ack !== 4'(1 << e.idx) || rdata !== e.data) begin
                        n_fail++;
                        $display("FAIL ack_data cycle=%0d got ack=%b rdata=%h want ack=%b rdata=%h",
                                 cyc, ack, rdata, 4'(1 << e.idx), e.data);
                    end
                end
                ack_cyc[ai] = cyc;
                if (rem[ai] > 0) begin
                    rem[ai]--;
                    if (rem[ai] == 0) req[ai] = 1'b0;
                end
            end
            left = 0;
            for (int i = 0; i < NREQ; i++) left += rem[i];
            if (left == 0 && !busy) break;
            if (cyc >= budget) begin
                n_chk++; n_fail++;
                $display("FAIL timeout after %0d cycles, %0d acks still outstanding", cyc, sb.size());
                clear_inputs();
                break;
            end
        end
        last_cyc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (gnt !== '0)     begin n_fail++; $display("FAIL reset_gnt got %b want 0", gnt); end
        n_chk++; if (ack !== '0)     begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
        n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (reg_en !== 1'b0) begin n_fail++; $display("FAIL reset_reg_en got %b want 0", reg_en); end
        n_chk++; if (rdata !== '0)   begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_chk++; if (reg_din !== '0) begin n_fail++; $display("FAIL reset_reg_din got %h want 0", reg_din); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_write();
        issue(2, 1'b1, 32'hDEADBEEF, 1, 1'b0);
        push(2, 32'hDEADBEEF);
        run(20);
        n_chk++; if (en_cnt !== 1 || en_cyc !== 1) begin n_fail++; $display("FAIL sw_reg_en got cnt=%0d cyc=%0d want 1/1", en_cnt, en_cyc); end
        n_chk++; if (ack_cyc[2] !== 2) begin n_fail++; $display("FAIL sw_ack_cycle got %0d want 2", ack_cyc[2]); end
        n_chk++; if (last_cyc !== 3)   begin n_fail++; $display("FAIL sw_busy_low_cycle got %0d want 3", last_cyc); end
        n_chk++; if (stor !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_register got %h want deadbeef", stor); end
    endtask

    task automatic test_all_read();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            issue(i, 1'b0, 32'h0, 1, 1'b0);
            push(i, 32'hDEADBEEF);
        end
        run(40);
        for (int i = 0; i < NREQ; i++) begin
            n_chk++;
            if (ack_cyc[i] !== 2 * (i + 1)) begin
                n_fail++;
                $display("FAIL rd_ack_cycle req=%0d got %0d want %0d", i, ack_cyc[i], 2 * (i + 1));
            end
        end
        n_chk++; if (en_cnt !== 0) begin n_fail++; $display("FAIL rd_reg_en got %0d want 0", en_cnt); end
        // Pointer back at 0: requester 0 must beat requester 3.
        issue(3, 1'b0, 32'h0, 1, 1'b0);
        issue(0, 1'b0, 32'h0, 1, 1'b0);
        push(0, 32'hDEADBEEF);
        push(3, 32'hDEADBEEF);
        run(20);
    endtask

    task automatic test_write_then_read();
        issue(0, 1'b1, 32'h0000_00A5, 1, 1'b0);
        push(0, 32'h0000_00A5);
        run(20);
        issue(2, 1'b0, 32'hFFFF_FFFF, 1, 1'b0);
        push(2, 32'h0000_00A5);
        run(20);
        n_chk++; if (en_cnt !== 0) begin n_fail++; $display("FAIL wr_rd_reg_en got %0d want 0", en_cnt); end
        n_chk++; if (reg_din !== 32'h0000_00A5) begin n_fail++; $display("FAIL wr_rd_reg_din got %h want a5", reg_din); end
    endtask

    task automatic test_lock();
        do_reset();
        issue(1, 1'b0, 32'h0, 4, 1'b1);
        issue(3, 1'b1, 32'h3333_0003, 1, 1'b0);
        for (int k = 0; k < 4; k++) push(1, 32'h0000_00A5);
        push(3, 32'h3333_0003);
        run(60);
        n_chk++; if (ack_cyc[3] !== 10) begin n_fail++; $display("FAIL lock_r1_cycle got %0d want 10", ack_cyc[3]); end
        // Second round: a fresh lock must again get the full four grants.
        issue(1, 1'b0, 32'h0, 4, 1'b1);
        issue(3, 1'b0, 32'h0, 1, 1'b0);
        for (int k = 0; k < 4; k++) push(1, 32'h3333_0003);
        push(3, 32'h3333_0003);
        run(60);
        n_chk++; if (ack_cyc[1] !== 8) begin n_fail++; $display("FAIL lock_r2_owner_cycle got %0d want 8", ack_cyc[1]); end
        lock = '0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        issue(1, 1'b1, 32'h0BAD_F00D, 1, 1'b0);
        push(1, 32'h0BAD_F00D);
        run(20);
        issue(2, 1'b1, 32'h1234_5678, 1, 1'b0);
        @(posedge clk); #1;
        n_chk++; if (gnt !== 4'b0100 || reg_en !== 1'b1) begin n_fail++; $display("FAIL abort_grant got gnt=%b en=%b want 0100/1", gnt, reg_en); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (gnt !== '0 || ack !== '0 || busy !== 1'b0 || reg_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs got gnt=%b ack=%b busy=%b en=%b want all 0", gnt, ack, busy, reg_en);
        end
        clear_inputs();
        @(negedge clk); #1;
        n_chk++; if (stor !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL abort_register got %h want 0badf00d", stor); end
        rst_n = 1'b1;
        issue(3, 1'b0, 32'h0, 1, 1'b0);
        issue(0, 1'b0, 32'h0, 1, 1'b0);
        push(0, 32'h0BAD_F00D);
        push(3, 32'h0BAD_F00D);
        run(20);
        n_chk++; if (ack_cyc[0] !== 2) begin n_fail++; $display("FAIL abort_pointer got %0d want 2", ack_cyc[0]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_all_read();
        test_write_then_read();
        test_lock();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter and sequencer sharing one 32-bit storage register (enable/data-in/data-out, captures on the falling clock edge while enabled) between NREQ requesters. It accepts read or write requests, drives the register's enable and data-in for exactly one cycle per write, and returns the register contents to the winning requester with a one-cycle acknowledge. It sits between the client blocks and the storage register. It is the only block allowed to drive that register's enable.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DATA_W, 32: data width; must match the storage register.
- MAX_LOCK, 4: maximum consecutive grants to one locked requester, 1..15.

- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-requester request, held high until ack.
- we  in  NREQ  per-requester write (1) / read (0), stable while req is high.
- lock  in  NREQ  keep priority after this access.
- wdata  in  NREQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W].
- gnt  out  NREQ  one-hot grant, high in GRANT and ACK.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  register contents, valid while ack is high.
- busy  out  1  high whenever state is not IDLE.
- reg_en  out  1  storage register enable.
- reg_din  out  DATA_W  storage register data in.
- reg_dout  in  DATA_W  storage register data out.

## Operation
- Reset values: state IDLE; gnt, ack, busy, reg_en = 0; rdata, reg_din = 0; round-robin pointer = 0; lock owner none; lock count = 0.
- FSM states: IDLE, GRANT, ACK.
  - IDLE → GRANT when any req bit is high.
  - GRANT → ACK always.
  - ACK → GRANT if a request is pending, otherwise IDLE. There is no IDLE bubble between back-to-back transactions.
- Selection happens on entry to GRANT.
  - Lock active and owner's req high, with lock count < MAX_LOCK: the owner wins.
  - Otherwise: the first req bit at or after the pointer, wrapping NREQ-1 → 0.
- GRANT cycle:
  - gnt = winner.
  - Write: reg_en = 1 and reg_din = wdata of the winner, both registered outputs valid for the whole cycle. The register captures at the falling edge mid-cycle.
  - Read: reg_en = 0. reg_din holds its previous value.
- ACK cycle:
  - ack = gnt.
  - rdata = reg_dout sampled at the rising edge ending GRANT. A write therefore returns the newly written value (write-through readback).
  - reg_en = 0.
- Pointer update at ACK: pointer = winner+1 mod NREQ, with one exception. If the winner holds lock and lock count < MAX_LOCK, the pointer is unchanged and lock count increments.
- Lock release: the owner releases when lock is low at its ACK, or when lock count reaches MAX_LOCK. On release, lock count = 0 and the pointer advances past the owner.
- Locked owner drops req: lock is released immediately and normal round-robin applies.
- req withdrawn during GRANT: this is a protocol violation. The transaction still completes and ack is still issued. A write is not aborted.
- we and wdata are sampled only in the cycle entering GRANT. Later changes have no effect.

## Timing
- Request seen high at rising edge N (state IDLE) → GRANT during cycle N+1 → ack high during cycle N+2.
- Latency: 2 cycles from idle.
- Sustained throughput: one access per 2 cycles.
- Only one of reg_en/ack-related writes can occur per transaction. reg_en is never high for two consecutive cycles.
- Simultaneous requests are served in pointer order with no starvation. Worst-case wait is (NREQ-1)*MAX_LOCK + NREQ-1 transactions.
- Asynchronous reset mid-GRANT:
  - All outputs clear immediately.
  - If reset arrives before the falling edge, the register write does not occur.
  - No ack is issued for the aborted transaction.
- Reset deassertion is synchronised externally. The first possible GRANT is the cycle after the first rising edge with rst_n high.

## Structure
- Package ram_arb_pkg holds:
  - DATA_W default.
  - State enum {IDLE, GRANT, ACK}.
  - Lock-count width constant (4 bits).
- Sub-module rr_pick: combinational, takes req and pointer, returns a one-hot winner and a valid flag. It is reused for the lock-bypass compare.
- The FSM, pointer, lock counter and output registers live in ram_arbiter.

## Test plan
- Single write: after reset, req[2]=1, we[2]=1, wdata[2]=32'hDEADBEEF → reg_en=1 in cycle 1 only; ack[2] in cycle 2 with rdata=32'hDEADBEEF; busy low in cycle 3.
- All four requesters reading simultaneously, pointer 0 → ack order 0,1,2,3 on cycles 2,4,6,8; pointer ends at 0.
- Lock: req[1] held with lock[1]=1, MAX_LOCK=4, req[3] also high → four consecutive grants to requester 1, then requester 3; the lock counter resets.
- Write then read: requester 0 writes 32'h0000_00A5, then requester 2 reads → requester 2's rdata = 32'h0000_00A5; reg_en stays low during the read.
- Reset mid-GRANT: rst_n low before the falling edge of a write to 32'h1234_5678 → register keeps its old value; gnt, ack, busy, reg_en = 0 at once; pointer = 0.
